alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, minimum 8.
REQ-002 Parameter SHAMT_W, default 5: shift-amount width; the block SHALL require WIDTH = 2^SHAMT_W.
REQ-003 clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present on data_operandA, data_operandB, ctrl_ALUopcode and ctrl_shiftamt.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 data_operandA, data_operandB  input  WIDTH  signed two's-complement operands.
REQ-008 ctrl_ALUopcode  input  5  operation select.
REQ-009 ctrl_shiftamt  input  SHAMT_W  shift amount for SLL/SRA.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 data_result  output  WIDTH  registered result.
REQ-013 isNotEqual, isLessThan, overflow, exception  output  1 each  registered flags.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Transfer rules: accept on in_valid & in_ready; retire on out_valid & out_ready.
REQ-016 On accept, operands, opcode and shift amount SHALL be captured; input changes after accept SHALL have no effect.
REQ-017 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRA (arithmetic), 6 MUL, 7 DIV; opcodes 8-31 SHALL behave as ADD.
REQ-018 Opcodes 0-5 and 8-31 SHALL go IDLE->DONE, with out_valid high the cycle after accept (latency 1).
REQ-019 MUL SHALL be signed iterative shift-add over exactly WIDTH cycles, then DONE (out_valid WIDTH+1 cycles after accept).
REQ-020 MUL result SHALL be the low WIDTH bits of the 2*WIDTH product.
REQ-021 MUL overflow=1 iff the full product is not representable in signed WIDTH bits.
REQ-022 DIV SHALL be signed restoring division over exactly WIDTH cycles, truncating toward zero, with the remainder discarded and latency WIDTH+1.
REQ-023 DIV with B=0 SHALL go directly to DONE (latency 1) with result 0, exception=1 and overflow=0.
REQ-024 DIV of the most negative value by -1 SHALL return the most negative value with overflow=1, latency WIDTH+1.
REQ-025 ADD/SUB overflow SHALL be signed overflow (operand signs agree, result sign differs, with B's sign inverted for SUB); all other opcodes SHALL give overflow=0.
REQ-026 exception SHALL be 1 only for DIV by zero.
REQ-027 isNotEqual and isLessThan SHALL be the signed compare of the captured A and B, registered with every result regardless of opcode.
REQ-028 In DONE, outputs SHALL hold stable while out_ready=0; on retire the FSM SHALL go to IDLE with out_valid=0 the next cycle.
REQ-029 in_valid in DONE SHALL NOT be accepted; no back-to-back accept occurs before the cycle after retire.
REQ-030 Shift amounts SHALL use all SHAMT_W bits; shift amount 0 SHALL return A unchanged.

Reset
REQ-031 reset_n=0 SHALL immediately (asynchronously) force IDLE and data_result=0, out_valid=0, overflow=0, exception=0, isNotEqual=0, isLessThan=0, with in_ready=1.
REQ-032 Reset asserted mid-MUL or mid-DIV SHALL abort the operation with no result ever emitted; the first accept after release SHALL proceed normally.

Verification (WIDTH=32)
REQ-033 ADD 0x7FFFFFFF+0x00000001 -> data_result 0x80000000, overflow=1, isLessThan=0, out_valid 1 cycle after accept.
REQ-034 MUL -3*7 -> 0xFFFFFFEB, overflow=0, out_valid exactly 33 cycles after accept, in_ready=0 throughout; MUL 0x00010000*0x00010000 -> 0x00000000, overflow=1.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; DIV 5/0 -> 0, exception=1, latency 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, overflow=1.
REQ-036 SRA 0x80000000 by 31 -> 0xFFFFFFFF; SLL 0x00000001 by 31 -> 0x80000000, overflow=0.
REQ-037 Hold out_ready=0 for 5 cycles in DONE while driving new in_valid and operands -> result and flags unchanged, in_ready=0, the new request is not accepted, and it is accepted the cycle after retire.
REQ-038 Assert reset_n=0 at MUL cycle 10 -> all outputs 0 and in_ready=1 without a clock edge; after release no stale out_valid appears.

Source files
------------

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Valid/ready ALU with single-cycle ADD/SUB/AND/OR/SLL/SRA and WIDTH-cycle
//   iterative signed MUL (shift-add) and signed DIV (restoring).
//   WIDTH must equal 2**SHAMT_W.
//
// Ports
//   clock, reset_n                 clock, asynchronous active-low reset
//   in_valid / in_ready            request handshake (ready only in IDLE)
//   data_operandA/B                signed operands
//   ctrl_ALUopcode                 0 ADD,1 SUB,2 AND,3 OR,4 SLL,5 SRA,6 MUL,
//                                  7 DIV, 8-31 ADD
//   ctrl_shiftamt                  shift amount for SLL/SRA
//   out_valid / out_ready          result handshake (valid only in DONE)
//   data_result                    registered result
//   isNotEqual, isLessThan         signed compare of the accepted operands
//   overflow, exception            registered status flags
// ---------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   data_operandA,
    input  logic signed [WIDTH-1:0]   data_operandB,
    input  logic        [4:0]         ctrl_ALUopcode,
    input  logic        [SHAMT_W-1:0] ctrl_shiftamt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   data_result,
    output logic                      isNotEqual,
    output logic                      isLessThan,
    output logic                      overflow,
    output logic                      exception
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;

    localparam logic [SHAMT_W-1:0]      LAST_CNT = SHAMT_W'(WIDTH - 1);
    localparam logic signed [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    // Unsigned magnitude; the most negative value maps to 2**(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Upper WIDTH+1 bits of a 2*WIDTH product must be a pure sign extension.
    function automatic logic fits_signed(input logic [WIDTH:0] hi);
        return (hi == '0) || (hi == '1);
    endfunction

    state_t state_q, state_d;
    logic [SHAMT_W-1:0]      cnt_q, cnt_d;
    logic signed [WIDTH-1:0] res_q, res_d;
    logic                    ovf_q, ovf_d, exc_q, exc_d, ne_q, ne_d, lt_q, lt_d;

    // Iterative datapath state (not reset; only meaningful in MUL/DIV)
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d, rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic               neg_q, neg_d, min_neg1_q, min_neg1_d;

    logic               accept, last_step;
    logic [2*WIDTH-1:0] mul_acc_nxt, mul_prod;
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt, div_signed;
    logic signed [WIDTH-1:0] add_res, sub_res;

    assign accept    = in_valid && (state_q == IDLE);
    assign last_step = (cnt_q == LAST_CNT);

    // ---- state register ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            exc_q   <= 1'b0;
            ne_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            exc_q   <= exc_d;
            ne_q    <= ne_d;
            lt_q    <= lt_d;
        end
    end

    always_ff @(posedge clock) begin
        acc_q      <= acc_d;
        mcand_q    <= mcand_d;
        mplier_q   <= mplier_d;
        rem_q      <= rem_d;
        quo_q      <= quo_d;
        dvsr_q     <= dvsr_d;
        neg_q      <= neg_d;
        min_neg1_q <= min_neg1_d;
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ctrl_ALUopcode == OP_MUL)
                        state_d = MUL;
                    else if (ctrl_ALUopcode == OP_DIV && data_operandB != '0)
                        state_d = DIV;
                    else
                        state_d = DONE;
                end
            end
            MUL, DIV: if (last_step) state_d = DONE;
            DONE:     if (out_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ---- outputs ----
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        data_result = res_q;
        overflow    = ovf_q;
        exception   = exc_q;
        isNotEqual  = ne_q;
        isLessThan  = lt_q;
    end

    // ---- datapath ----
    always_comb begin
        add_res     = data_operandA + data_operandB;
        sub_res     = data_operandA - data_operandB;

        // One shift-add step on magnitudes; sign applied at the end.
        mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_prod    = neg_q ? -mul_acc_nxt : mul_acc_nxt;

        // One restoring step: shift next dividend bit into the remainder.
        rem_sh      = {rem_q, quo_q[WIDTH-1]};
        div_ge      = (rem_sh >= {1'b0, dvsr_q});
        rem_nxt     = div_ge ? WIDTH'(rem_sh - {1'b0, dvsr_q}) : rem_sh[WIDTH-1:0];
        quo_nxt     = {quo_q[WIDTH-2:0], div_ge};
        div_signed  = neg_q ? -quo_nxt : quo_nxt;

        cnt_d      = cnt_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        exc_d      = exc_q;
        ne_d       = ne_q;
        lt_d       = lt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        neg_d      = neg_q;
        min_neg1_d = min_neg1_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    ne_d       = (data_operandA != data_operandB);
                    lt_d       = (data_operandA < data_operandB);
                    ovf_d      = 1'b0;
                    exc_d      = 1'b0;
                    cnt_d      = '0;
                    neg_d      = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    case (ctrl_ALUopcode)
                        OP_SUB: begin
                            res_d = sub_res;
                            ovf_d = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                                    (sub_res[WIDTH-1] != data_operandA[WIDTH-1]);
                        end
                        OP_AND: res_d = data_operandA & data_operandB;
                        OP_OR:  res_d = data_operandA | data_operandB;
                        OP_SLL: res_d = data_operandA << ctrl_shiftamt;
                        OP_SRA: res_d = data_operandA >>> ctrl_shiftamt;
                        OP_MUL: begin
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, magnitude(data_operandA)};
                            mplier_d = magnitude(data_operandB);
                        end
                        OP_DIV: begin
                            if (data_operandB == '0) begin
                                res_d = '0;
                                exc_d = 1'b1;
                            end else begin
                                rem_d      = '0;
                                quo_d      = magnitude(data_operandA);
                                dvsr_d     = magnitude(data_operandB);
                                min_neg1_d = (data_operandA == MIN_VAL) && (data_operandB == '1);
                            end
                        end
                        default: begin
                            res_d = add_res;
                            ovf_d = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                                    (add_res[WIDTH-1] != data_operandA[WIDTH-1]);
                        end
                    endcase
                end
            end
            MUL: begin
                acc_d    = mul_acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHAMT_W'(1);
                if (last_step) begin
                    res_d = mul_prod[WIDTH-1:0];
                    ovf_d = !fits_signed(mul_prod[2*WIDTH-1:WIDTH-1]);
                end
            end
            DIV: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + SHAMT_W'(1);
                if (last_step) begin
                    // MIN / -1 wraps to MIN on its own; only the flag is special.
                    res_d = div_signed;
                    ovf_d = min_neg1_q;
                end
            end
            default: ;
        endcase
    end

endmodule
